// File: rtl/down_timer_pkg.sv
// Shared constants for the down-counting timer: FSM state encoding and mode select values.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between the register block (master) and the down timer (slave).
interface down_timer_if #(parameter int W = 32);

    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         mode;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    modport slave (
        input  load_val, start, stop, mode, pause,
        output count, busy, tc, done
    );

    modport master (
        output load_val, start, stop, mode, pause,
        input  count, busy, tc, done
    );

endinterface

// File: rtl/down_timer.sv
// Programmable down timer: one-shot or periodic auto-reload, one-cycle registered terminal-count pulse.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst,
    down_timer_if.slave bus
);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_reload;
    logic           r_mode;
    logic           r_tc;
    logic           w_busy;
    logic           w_done;
    logic           w_start_ok;
    logic           w_advance;
    logic           w_last;

    // A start carrying a zero load is treated as if start were absent.
    assign w_start_ok = bus.start && (bus.load_val != '0);
    assign w_advance  = (r_state == RUN) && !bus.pause;
    assign w_last     = (r_count == W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.stop) begin
            w_next = IDLE;
        end else if (w_start_ok) begin
            w_next = RUN;
        end else if (w_advance && w_last && (r_mode == MODE_ONESHOT)) begin
            w_next = DONE;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            RUN:     w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= MODE_ONESHOT;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.stop) begin
                r_count <= '0;
            end else if (w_start_ok) begin
                r_count  <= bus.load_val;
                r_reload <= bus.load_val;
                r_mode   <= bus.mode;
            end else if (w_advance) begin
                if (w_last) begin
                    r_tc    <= 1'b1;
                    r_count <= (r_mode == MODE_PERIODIC) ? r_reload : '0;
                end else begin
                    r_count <= r_count - W'(1);
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = w_busy;
    assign bus.tc    = r_tc;
    assign bus.done  = w_done;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_down_timer;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    down_timer_if #(.W(W)) bus ();

    down_timer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what the timer is doing, in terms of remaining ticks.
    logic [W-1:0] m_count;
    logic [W-1:0] m_period;
    bit           m_periodic;
    bit           m_running;
    bit           m_finished;
    bit           m_tc;

    task automatic model_clear();
        m_count = '0; m_period = '0; m_periodic = 0;
        m_running = 0; m_finished = 0; m_tc = 0;
    endtask

    task automatic model(input bit st, input bit sp, input logic [W-1:0] lv, input bit md, input bit ps);
        m_tc = 0;
        if (sp) begin
            m_running = 0; m_finished = 0; m_count = '0;
        end else if (st && lv != 0) begin
            m_running = 1; m_finished = 0; m_count = lv; m_period = lv; m_periodic = md;
        end else if (m_running && !ps) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (m_periodic) m_count = m_period;
                else begin
                    m_count = '0; m_running = 0; m_finished = 1;
                end
            end else begin
                m_count = m_count - 1'b1;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input bit st, input bit sp, input logic [W-1:0] lv, input bit md, input bit ps);
        bus.start = st; bus.stop = sp; bus.load_val = lv; bus.mode = md; bus.pause = ps;
        model(st, sp, lv, md, ps);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, bus.load_val, bus.mode, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.mode = 0; bus.load_val = '0;
        model_clear();
        #2;
        n_cmp++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_por: count=%0d busy=%b tc=%b done=%b, required 0/0/0/0", bus.count, bus.busy, bus.tc, bus.done);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        step(1, 0, 16'd8, 0, 0);
        idle(3);
        n_cmp++;
        if (bus.count !== 16'd5 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prerun: count=%0d busy=%b, required 5/1", bus.count, bus.busy);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: count=%0d busy=%b tc=%b done=%b, required 0/0/0/0", bus.count, bus.busy, bus.tc, bus.done);
        end
        model_clear();
        @(posedge clk); #1; rst = 1'b0;
        idle(2);
        n_cmp++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: count=%0d busy=%b tc=%b done=%b, required 0/0/0/0", bus.count, bus.busy, bus.tc, bus.done);
        end
    endtask

    task automatic test_oneshot();
        step(1, 0, 16'd4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.count !== 16'(4 - i) || bus.busy !== 1'b1 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL oneshot_cnt[%0d]: count=%0d busy=%b tc=%b done=%b, required %0d/1/0/0", i, bus.count, bus.busy, bus.tc, bus.done, 4 - i);
            end
            if (i < 3) idle(1);
        end
        idle(1);
        n_cmp++;
        if (bus.count !== '0 || bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_tc: count=%0d tc=%b done=%b busy=%b, required 0/1/1/0", bus.count, bus.tc, bus.done, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'd4, 0, (i == 1));
            n_cmp++;
            if (bus.tc !== 1'b0 || bus.done !== 1'b1 || bus.count !== '0) begin
                n_err++;
                $display("FAIL oneshot_hold[%0d]: tc=%b done=%b count=%0d, required 0/1/0", i, bus.tc, bus.done, bus.count);
            end
        end
        step(1, 0, 16'd2, 0, 0);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.count !== 16'd2) begin
            n_err++;
            $display("FAIL oneshot_restart: done=%b busy=%b count=%0d, required 0/1/2", bus.done, bus.busy, bus.count);
        end
        step(0, 1, 16'd0, 0, 0);
    endtask

    task automatic test_periodic();
        int tcs;
        tcs = 0;
        step(1, 0, 16'd3, 1, 0);
        for (int i = 1; i <= 30; i++) begin
            idle(1);
            if (bus.tc === 1'b1) tcs++;
            n_cmp++;
            if (bus.count !== 16'(3 - (i % 3)) || bus.tc !== (i % 3 == 0) || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL periodic3[%0d]: count=%0d tc=%b busy=%b, required %0d/%b/1", i, bus.count, bus.tc, bus.busy, 3 - (i % 3), (i % 3 == 0));
            end
        end
        n_cmp++;
        if (tcs != 10) begin
            n_err++;
            $display("FAIL periodic3_total: tc pulses=%0d, required 10", tcs);
        end
        step(1, 0, 16'd1, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            idle(1);
            n_cmp++;
            if (bus.tc !== 1'b1 || bus.count !== 16'd1 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL periodic1[%0d]: tc=%b count=%0d busy=%b, required 1/1/1", i, bus.tc, bus.count, bus.busy);
            end
        end
        step(0, 1, 16'd0, 0, 0);
    endtask

    task automatic test_pause();
        int left;
        left = 5;
        step(1, 0, 16'd5, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            bit p;
            p = (i >= 3 && i <= 5);
            step(0, 0, 16'd5, 0, p);
            if (!p) left--;
            n_cmp++;
            if (i < 8) begin
                if (bus.count !== 16'(left) || bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL pause[%0d]: count=%0d tc=%b busy=%b, required %0d/0/1", i, bus.count, bus.tc, bus.busy, left);
                end
            end else begin
                if (bus.count !== '0 || bus.tc !== 1'b1 || bus.done !== 1'b1) begin
                    n_err++;
                    $display("FAIL pause_tc: count=%0d tc=%b done=%b, required 0/1/1", bus.count, bus.tc, bus.done);
                end
            end
        end
        step(0, 1, 16'd0, 0, 0);
    endtask

    task automatic test_priority();
        step(1, 0, 16'd2, 0, 0);
        idle(1);
        n_cmp++;
        if (bus.count !== 16'd1) begin
            n_err++;
            $display("FAIL prio_setup: count=%0d, required 1", bus.count);
        end
        step(1, 0, 16'd6, 0, 0);
        n_cmp++;
        if (bus.tc !== 1'b0 || bus.count !== 16'd6 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL prio_restart: tc=%b count=%0d busy=%b, required 0/6/1", bus.tc, bus.count, bus.busy);
        end
        step(1, 0, 16'd0, 0, 0);
        n_cmp++;
        if (bus.count !== 16'd5 || bus.busy !== 1'b1 || bus.tc !== 1'b0) begin
            n_err++;
            $display("FAIL prio_zero_run: count=%0d busy=%b tc=%b, required 5/1/0", bus.count, bus.busy, bus.tc);
        end
        step(1, 1, 16'd7, 1, 0);
        n_cmp++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            n_err++;
            $display("FAIL prio_stop: count=%0d busy=%b done=%b tc=%b, required 0/0/0/0", bus.count, bus.busy, bus.done, bus.tc);
        end
        step(1, 0, 16'd0, 1, 0);
        n_cmp++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            n_err++;
            $display("FAIL prio_zero_idle: count=%0d busy=%b done=%b tc=%b, required 0/0/0/0", bus.count, bus.busy, bus.done, bus.tc);
        end
    endtask

    task automatic test_reload_isolation();
        step(1, 0, 16'd4, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 16'd9, 1, 0);
            n_cmp++;
            if (bus.count !== 16'(4 - (i % 4)) || bus.tc !== (i % 4 == 0)) begin
                n_err++;
                $display("FAIL reload_iso[%0d]: count=%0d tc=%b, required %0d/%b", i, bus.count, bus.tc, 4 - (i % 4), (i % 4 == 0));
            end
        end
        step(0, 1, 16'd0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit st, sp, md, ps;
            logic [W-1:0] lv;
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 24) == 0);
            md = 1'($urandom_range(0, 1));
            ps = ($urandom_range(0, 3) == 0);
            lv = W'($urandom_range(0, 6));
            step(st, sp, lv, md, ps);
            n_cmp++;
            if (bus.count !== m_count || bus.tc !== m_tc || bus.busy !== m_running || bus.done !== m_finished) begin
                n_err++;
                $display("FAIL random[%0d]: count=%0d tc=%b busy=%b done=%b, required %0d/%b/%b/%b",
                         i, bus.count, bus.tc, bus.busy, bus.done, m_count, m_tc, m_running, m_finished);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_priority();
        test_reload_isolation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Programmable down-counting timer for the RGB LED IP, complementing the free-running up counter. Loads a start value and counts down to terminal. Emits a one-cycle terminal-count pulse, either once (one-shot) or every N cycles (periodic auto-reload). Used for PWM period generation, blink intervals and timeouts driven from AXI-written registers.

Parameters:
W, 32, counter/load width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
load_val  input  W  start/reload value, sampled only on the cycle start is high
start  input  1  single-cycle request to (re)start the timer with load_val
stop  input  1  abort; return to IDLE
mode  input  1  0 = one-shot, 1 = periodic; sampled with start
pause  input  1  level; while high in RUN, count holds
count  output  W  current count value (registered)
busy  output  1  high while state is RUN (including paused)
tc  output  1  one-cycle terminal-count pulse (registered)
done  output  1  level, high in DONE (one-shot finished) until next start/stop

Behaviour:
- Reset (async, rst=1): state IDLE, count=0, reload reg=0, mode reg=0, busy=0, tc=0, done=0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Per-cycle input priority: stop > start > pause > decrement.
- stop=1 (any state): next state IDLE, count<=0, tc<=0, done<=0. start is ignored that cycle.
- start=1 with load_val!=0 (any state, stop=0): count<=load_val, reload reg<=load_val, mode reg<=mode, next state RUN, tc<=0. Restarting mid-run discards the current count with no tc, even if count==1.
- start=1 with load_val==0: ignored. No state, count, tc or done change.
- RUN, pause=1: count, state and tc-generation are frozen. tc stays 0.
- RUN, pause=0, count>1: count<=count-1, tc<=0.
- RUN, pause=0, count==1:
  - tc<=1 for exactly one cycle.
  - One-shot: count<=0, next state DONE.
  - Periodic: count<=reload reg, stay in RUN.
- Timing: start sampled at edge k gives count=N after edge k. With no pause, tc is high after edge k+N for one cycle.
  - One-shot: done rises together with tc.
  - Periodic: tc repeats every N cycles exactly. N=1 gives tc high every cycle.
- Reload uses the latched reload reg. Changes on load_val while running have no effect until the next start.
- IDLE and DONE: count holds (0), tc=0, pause and mode ignored.
- Asserting rst mid-run immediately forces reset values. No tc is generated.
- Arithmetic: unsigned W-bit. Decrement never underflows because count==0 is never reached in RUN while decrementing.

Decomposition:
- Shared package (team's rgb_leds_pkg): state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10; mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Single module, no sub-module. The datapath (count/reload regs, decrement, ==1 compare) and the 3-state FSM live together.

Test Plan:
- Reset: assert rst mid-run with count=5 -> count=0, busy=0, tc=0, done=0 immediately (async); after release, state is IDLE.
- One-shot: load_val=4, mode=0, start pulse at edge k -> count 4,3,2,1 after edges k..k+3; after edge k+4: count=0, tc=1 (one cycle), done=1, busy=0. done stays high until the next start.
- Periodic: load_val=3, mode=1 -> tc pulses exactly every 3 cycles across 10 periods; count sequence 3,2,1,3,2,1...; busy stays 1. load_val=1 -> tc high every cycle.
- Pause: one-shot load_val=5, pause high for 3 cycles when count=3 -> count holds at 3 for 3 cycles, no tc; tc arrives 3 cycles later than the unpaused case (8 cycles after start).
- Priority/restart: start with load_val=6 while count==1 -> no tc, count=6. Then stop and start asserted in the same cycle -> IDLE, count=0. Then start with load_val=0 -> no change.
- Reload isolation: periodic load_val=4, change load_val to 9 during RUN -> period remains 4 until the next start.
